// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared N64 controller encodings and defaults
package n64_pkg;

    typedef logic [2:0] n64_state_t;

    localparam n64_state_t ST_IDLE       = 3'd0;
    localparam n64_state_t ST_ISSUE      = 3'd1;
    localparam n64_state_t ST_ACK        = 3'd2;
    localparam n64_state_t ST_WAIT       = 3'd3;
    localparam n64_state_t ST_STOP_ISSUE = 3'd4;
    localparam n64_state_t ST_STOP_ACK   = 3'd5;
    localparam n64_state_t ST_STOP_WAIT  = 3'd6;
    localparam n64_state_t ST_FINISH     = 3'd7;

    localparam int N64_MAX_RESP_BYTES = 4;
    localparam int N64_ACK_TIMEOUT    = 15;

    function automatic logic length_valid(input logic [2:0] len, input int max_bytes);
        return (len != 3'd0) && (int'(len) <= max_bytes);
    endfunction

endpackage

// File: rtl/n64_transmit_packet_if.sv
// rtl/n64_transmit_packet_if.sv - packet sequencer to byte/bit stage handshake
interface n64_transmit_packet_if;

    logic       byte_trigger;
    logic [7:0] byte_data;
    logic       byte_busy;
    logic       stop_trigger;
    logic       stop_busy;

    modport master (
        output byte_trigger,
        output byte_data,
        output stop_trigger,
        input  byte_busy,
        input  stop_busy
    );

    modport slave (
        input  byte_trigger,
        input  byte_data,
        input  stop_trigger,
        output byte_busy,
        output stop_busy
    );

endinterface

// File: rtl/n64_handshake_timer.sv
// rtl/n64_handshake_timer.sv - clear/enable watchdog counter with terminal-count flag
module n64_handshake_timer #(
    parameter int LIMIT = 15
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;
    logic         at_last;

    assign at_last = (count == W'(LIMIT - 1));
    // tc marks the LIMIT-th enabled cycle since the last clear
    assign tc      = enable && at_last;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/n64_transmit_packet.sv
// rtl/n64_transmit_packet.sv - N64 response packet sequencer feeding byte and stop-bit stages
module n64_transmit_packet
    import n64_pkg::*;
#(
    parameter int MAX_BYTES   = N64_MAX_RESP_BYTES,
    parameter int ACK_TIMEOUT = N64_ACK_TIMEOUT
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [1:0]                   load_addr,
    input  logic [7:0]                   load_data,
    input  logic                         start,
    input  logic [2:0]                   length,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    n64_transmit_packet_if.master        dn
);

    n64_state_t state, next_state;

    logic [7:0] buffer [0:3];
    logic [1:0] idx;
    logic [2:0] pkt_len;
    logic [7:0] byte_q;
    logic [7:0] first_byte;
    logic       start_ok;
    logic       start_bad;
    logic       more_bytes;
    logic       tmr_clear;
    logic       tmr_enable;
    logic       tmr_tc;
    logic       timeout;

    assign start_ok   = (state == ST_IDLE) && start && length_valid(length, MAX_BYTES);
    assign start_bad  = (state == ST_IDLE) && start && !length_valid(length, MAX_BYTES);
    assign more_bytes = ({1'b0, idx} + 3'd1) < pkt_len;
    // A load in the start cycle wins over the stored byte
    assign first_byte = (load && load_addr == 2'd0) ? load_data : buffer[0];

    assign tmr_clear  = (state == ST_ISSUE) || (state == ST_STOP_ISSUE);
    assign tmr_enable = (state == ST_ACK) || (state == ST_STOP_ACK);
    assign timeout    = tmr_tc && (((state == ST_ACK) && !dn.byte_busy) ||
                                   ((state == ST_STOP_ACK) && !dn.stop_busy));

    n64_handshake_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timer (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .tc      (tmr_tc)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (start_ok) next_state = ST_ISSUE;
            ST_ISSUE:      next_state = ST_ACK;
            ST_ACK: begin
                if (dn.byte_busy)  next_state = ST_WAIT;
                else if (tmr_tc)   next_state = ST_IDLE;
            end
            ST_WAIT:       if (!dn.byte_busy) next_state = more_bytes ? ST_ISSUE : ST_STOP_ISSUE;
            ST_STOP_ISSUE: next_state = ST_STOP_ACK;
            ST_STOP_ACK: begin
                if (dn.stop_busy)  next_state = ST_STOP_WAIT;
                else if (tmr_tc)   next_state = ST_IDLE;
            end
            ST_STOP_WAIT:  if (!dn.stop_busy) next_state = ST_FINISH;
            ST_FINISH:     next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != ST_IDLE) && (state != ST_FINISH);
        done            = (state == ST_FINISH);
        dn.byte_trigger = (state == ST_ISSUE);
        dn.stop_trigger = (state == ST_STOP_ISSUE);
        dn.byte_data    = byte_q;
    end

    // byte_q only moves on ISSUE entry: the byte stage reads it live while sending
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) buffer[i] <= 8'h00;
            idx     <= 2'd0;
            pkt_len <= 3'd0;
            byte_q  <= 8'h00;
            error   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && load && (int'(load_addr) < MAX_BYTES)) begin
                buffer[load_addr] <= load_data;
            end
            if (start_ok) begin
                pkt_len <= length;
                idx     <= 2'd0;
                error   <= 1'b0;
                byte_q  <= first_byte;
            end else if (start_bad || timeout) begin
                error   <= 1'b1;
            end
            if ((state == ST_WAIT) && !dn.byte_busy && more_bytes) begin
                idx    <= idx + 2'd1;
                byte_q <= buffer[idx + 2'd1];
            end
        end
    end

endmodule

// File: tb/tb_n64_transmit_packet.sv
// tb/tb_n64_transmit_packet.sv - scoreboard bench for the N64 packet sequencer
module tb_n64_transmit_packet;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       load;
    logic [1:0] load_addr;
    logic [7:0] load_data;
    logic       start;
    logic [2:0] length;
    logic       busy;
    logic       done;
    logic       error;

    n64_transmit_packet_if dif ();

    n64_transmit_packet #(
        .MAX_BYTES   (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .load      (load),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dn        (dif)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    bit byte_respond = 1'b1;
    bit stop_respond = 1'b1;

    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int         obs_rd = 0;

    int         btrig_cnt = 0;
    int         strig_cnt = 0;
    int         done_cnt  = 0;
    int         viol_cnt  = 0;
    logic       prev_trig = 1'b0;
    logic [7:0] last_byte = 8'h00;

    // Byte stage model: busy rises 2 cycles after a trigger and lasts 32 cycles
    initial begin
        dif.byte_busy = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            if (dif.byte_trigger === 1'b1 && byte_respond) begin
                repeat (2) @(posedge sys_clk);
                #1 dif.byte_busy = 1'b1;
                repeat (32) @(posedge sys_clk);
                #1 dif.byte_busy = 1'b0;
            end
        end
    end

    initial begin
        dif.stop_busy = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            if (dif.stop_trigger === 1'b1 && stop_respond) begin
                repeat (2) @(posedge sys_clk);
                #1 dif.stop_busy = 1'b1;
                repeat (4) @(posedge sys_clk);
                #1 dif.stop_busy = 1'b0;
            end
        end
    end

    // Records observed traffic and protocol violations; all comparisons happen in the stimulus
    always @(negedge sys_clk) begin
        if (dif.byte_trigger === 1'b1) begin
            btrig_cnt++;
            obs_q.push_back(dif.byte_data);
            last_byte = dif.byte_data;
        end
        if (dif.stop_trigger === 1'b1) strig_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0) viol_cnt++;
        end
        if ((dif.byte_trigger | dif.stop_trigger) === 1'b1 && prev_trig === 1'b1) viol_cnt++;
        if (dif.byte_trigger === 1'b1 && dif.stop_trigger === 1'b1) viol_cnt++;
        if (busy === 1'b1 && dif.byte_busy === 1'b1 && dif.byte_data !== last_byte) viol_cnt++;
        prev_trig = dif.byte_trigger | dif.stop_trigger;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
        load = 1'b1; load_addr = addr; load_data = data;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] len);
        start = 1'b1; length = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic compare_bytes(input string tag);
        check({tag, "_count"}, obs_q.size() - obs_rd, exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            check({tag, "_byte"}, {24'd0, obs_q[obs_rd]}, {24'd0, exp_q.pop_front()});
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},         {31'd0, busy},             32'd0);
        check({tag, "_done"},         {31'd0, done},             32'd0);
        check({tag, "_error"},        {31'd0, error},            32'd0);
        check({tag, "_byte_trigger"}, {31'd0, dif.byte_trigger}, 32'd0);
        check({tag, "_byte_data"},    {24'd0, dif.byte_data},    32'd0);
        check({tag, "_stop_trigger"}, {31'd0, dif.stop_trigger}, 32'd0);
    endtask

    int snap_b, snap_s, snap_d, n;

    initial begin
        reset = 1'b1; load = 1'b0; load_addr = 2'd0; load_data = 8'h00;
        start = 1'b0; length = 3'd0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Identify response 0x05 0x00 0x02
        do_load(2'd0, 8'h05); do_load(2'd1, 8'h00); do_load(2'd2, 8'h02);
        exp_q.push_back(8'h05); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        snap_b = btrig_cnt; snap_s = strig_cnt; snap_d = done_cnt;
        do_start(3'd3);
        check("id_busy_cycle1", {31'd0, busy}, 32'd1);
        check("id_trigger_cycle1", {31'd0, dif.byte_trigger}, 32'd1);
        wait_idle("id_idle", 600);
        tick();
        compare_bytes("id");
        check("id_byte_triggers", btrig_cnt - snap_b, 3);
        check("id_stop_triggers", strig_cnt - snap_s, 1);
        check("id_done_pulses", done_cnt - snap_d, 1);
        check("id_error", {31'd0, error}, 32'd0);

        // Invalid lengths 0 and 5
        snap_b = btrig_cnt;
        do_start(3'd0);
        check("len0_error", {31'd0, error}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        do_start(3'd5);
        check("len5_error", {31'd0, error}, 32'd1);
        check("len5_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("len_bad_triggers", btrig_cnt - snap_b, 0);
        snap_d = done_cnt;
        exp_q.push_back(8'h05);
        do_start(3'd1);
        check("recover_error_cleared", {31'd0, error}, 32'd0);
        wait_idle("recover_idle", 300);
        tick();
        compare_bytes("recover");
        check("recover_done", done_cnt - snap_d, 1);

        // Byte stage never answers: abort exactly 15 cycles after ACK entry
        byte_respond = 1'b0;
        snap_b = btrig_cnt; snap_d = done_cnt;
        exp_q.push_back(8'h05);
        do_start(3'd3);
        repeat (15) tick();
        check("bto_busy_before", {31'd0, busy}, 32'd1);
        tick();
        check("bto_busy_after", {31'd0, busy}, 32'd0);
        check("bto_error", {31'd0, error}, 32'd1);
        check("bto_trigger_low", {31'd0, dif.byte_trigger}, 32'd0);
        repeat (10) tick();
        compare_bytes("bto");
        check("bto_triggers", btrig_cnt - snap_b, 1);
        check("bto_done", done_cnt - snap_d, 0);
        byte_respond = 1'b1;

        // Same-cycle load with start, then load and start attempts while busy
        snap_b = btrig_cnt; snap_d = done_cnt;
        exp_q.push_back(8'hAA); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        load = 1'b1; load_addr = 2'd0; load_data = 8'hAA;
        do_start(3'd3);
        load = 1'b0;
        repeat (5) tick();
        do_load(2'd1, 8'h77);
        tick();
        do_start(3'd1);
        wait_idle("busy_ign_idle", 600);
        tick();
        compare_bytes("busy_ign");
        check("busy_ign_triggers", btrig_cnt - snap_b, 3);
        check("busy_ign_done", done_cnt - snap_d, 1);

        // Reset during the second byte of a 4-byte packet
        do_load(2'd0, 8'h80); do_load(2'd1, 8'h01); do_load(2'd2, 8'h7F); do_load(2'd3, 8'hFF);
        snap_b = btrig_cnt;
        exp_q.push_back(8'h80); exp_q.push_back(8'h01);
        do_start(3'd4);
        n = 0;
        while (btrig_cnt - snap_b < 2 && n < 200) begin
            tick();
            n++;
        end
        check("rst_reach_byte2", btrig_cnt - snap_b, 2);
        repeat (5) tick();
        #2 reset = 1'b1;
        #1 check_outputs_zero("rst_mid");
        tick();
        reset = 1'b0;
        repeat (40) tick();
        compare_bytes("rst_mid");
        snap_d = done_cnt;
        exp_q.push_back(8'h00);
        do_start(3'd1);
        wait_idle("rst_clear_idle", 300);
        tick();
        compare_bytes("rst_clear");
        check("rst_clear_done", done_cnt - snap_d, 1);

        // Stop-bit stage never answers
        stop_respond = 1'b0;
        snap_s = strig_cnt; snap_d = done_cnt;
        exp_q.push_back(8'h00);
        do_start(3'd1);
        wait_idle("sto_idle", 300);
        tick();
        compare_bytes("sto");
        check("sto_error", {31'd0, error}, 32'd1);
        check("sto_stop_triggers", strig_cnt - snap_s, 1);
        check("sto_done", done_cnt - snap_d, 0);
        stop_respond = 1'b1;

        check("handshake_violations", viol_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n64_transmit_packet.md
# n64_transmit_packet

Packet sequencer upstream of the N64 byte transmitter. It holds a response of up to MAX_BYTES bytes, hands them MSB-byte-first to the byte stage over a trigger/busy handshake, then requests the protocol stop bit from the bit stage. Typical responses are the 3-byte identify (0x05 0x00 0x02) and the 4-byte button/stick status. Includes a handshake watchdog so a stalled downstream stage cannot hang the response path.

## Interface
- MAX_BYTES, 4, buffer depth and maximum packet length (1..4)
- ACK_TIMEOUT, 15, cycles allowed between a trigger and the matching busy rise
- sys_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  write load_data into buffer[load_addr]; honoured only when busy=0
- load_addr  in  2  buffer index, 0 = first byte sent
- load_data  in  8  byte to store
- start  in  1  begin packet; honoured only when busy=0
- length  in  3  bytes to send, sampled on start, valid 1..MAX_BYTES
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; set on invalid length or timeout, cleared by the next accepted start
- byte_trigger  out  1  one-cycle request to the byte stage
- byte_data  out  8  byte presented to the byte stage
- byte_busy  in  1  byte stage transmitting
- stop_trigger  out  1  one-cycle request for the stop bit to the bit stage
- stop_busy  in  1  bit stage transmitting

## Operation
- States:
  - IDLE
  - ISSUE: byte_trigger=1
  - ACK: wait for byte_busy=1
  - WAIT: wait for byte_busy=0
  - STOP_ISSUE: stop_trigger=1
  - STOP_ACK
  - STOP_WAIT
  - FINISH: done=1
- IDLE + start:
  - length 1..MAX_BYTES: latch length, idx←0, clear error, go ISSUE.
  - length 0 or >MAX_BYTES: error←1, stay IDLE, no done.
- ISSUE → ACK unconditionally, timer cleared.
- ACK:
  - byte_busy=1 → WAIT.
  - timer reaches ACK_TIMEOUT → error←1, IDLE.
- WAIT, byte_busy=0:
  - idx+1 < length: idx←idx+1, go ISSUE.
  - otherwise: go STOP_ISSUE.
- STOP_ISSUE, STOP_ACK and STOP_WAIT mirror ISSUE, ACK and WAIT, using stop_busy and the same timeout rule. STOP_WAIT with stop_busy=0 → FINISH.
- FINISH → IDLE.
- byte_data = buffer[idx], registered. It is updated only on entry to ISSUE and held stable until the next ISSUE, because the byte stage reads it live throughout transmission.
- load and start in the same IDLE cycle: the write lands first, so the new value is sent.
- load or start while busy=1 is ignored; the buffer is frozen during a packet.
- byte_busy or stop_busy asserting outside its ACK state is ignored.
- Reset (any time, including mid-packet):
  - state IDLE, buffer cleared to 0x00.
  - All outputs 0 immediately: busy, done, error, byte_trigger, byte_data, stop_trigger.

## Timing
- start sampled at edge 0 → busy=1 and byte_trigger=1 during cycle 1.
- Downstream busy is visible no earlier than cycle 2. ACK tolerates any delay up to ACK_TIMEOUT cycles counted from the ACK entry.
- Minimum gap between byte_busy falling and the next byte_trigger: 1 cycle.
- Triggers are exactly one cycle wide, never back-to-back.
- done is high for one cycle and busy falls in that same cycle. start is accepted again on the following edge.
- Timeout abort: busy falls and error rises in the same cycle; no trigger is left asserted.

## Structure
- Shared package n64_pkg holds:
  - state encodings (3-bit localparams)
  - N64_MAX_RESP_BYTES = 4
  - default ACK_TIMEOUT
- One sub-module, n64_handshake_timer: a clear/enable counter with a terminal-count flag. It is reused for both ACK states and by future receive-side watchdogs.

## Test plan
- Load 0x05,0x00,0x02, start with length=3, downstream busy rises 2 cycles after each trigger and lasts 32 cycles → byte_data sequence 0x05,0x00,0x02. Then one stop_trigger, done pulse, busy=0.
- length=0 and, separately, length=5 → error=1, no triggers, busy stays 0. A following valid start clears error.
- byte_busy held 0 after the first trigger → error=1 and busy=0 exactly ACK_TIMEOUT cycles after ACK entry, with no further triggers.
- load to address 1 during a packet → ignored. Same-cycle load 0xAA@0 with start → first byte_data=0xAA.
- Reset asserted mid-byte of a 4-byte packet (0x80,0x01,0x7F,0xFF) → all outputs 0 immediately, and buffer reads back 0x00 on the next length=1 packet.
- Start pulse during busy → ignored, single done per packet. stop_busy stuck low → timeout error, no done.
